// File: rtl/conv_ctrl.sv
// -----------------------------------------------------------------------------
// conv_ctrl
//
// Sequencing controller for a small convolution engine. One job walks through:
// serially loading the FILTER x FILTER filter bytes, then the IFMAP x IFMAP
// ifmap bytes, clearing the PE array accumulators, running the PE array until
// it reports completion (or a compute timeout trips), and draining the
// OUT x OUT result bytes through a parallel-to-serial output stage.
//
// Ports
//   clk             sole clock, all state updates on the rising edge
//   rst             asynchronous, active-high reset
//   start           begin a job (only looked at while idle)
//   abort           synchronous cancel of the current job
//   in_valid        input byte available
//   in_ready        controller is accepting input bytes (filter/ifmap load)
//   load_filter_en  shift strobe for the filter serial loader
//   load_ifmap_en   shift strobe for the ifmap serial loader
//   pe_clr          one-cycle PE accumulator clear
//   pe_en           PE array compute enable
//   done_compute    PE array finished its computation
//   out_shift_en    shift strobe for the output serializer
//   out_valid       output byte valid
//   out_ready       downstream accepts an output byte
//   busy            high whenever a job is in progress (including error)
//   done            one-cycle job-complete pulse
//   error           sticky compute-timeout flag, cleared by abort or reset
// -----------------------------------------------------------------------------
module conv_ctrl #(
    parameter int IFMAP   = 5,
    parameter int FILTER  = 3,
    parameter int OUT     = IFMAP - FILTER + 1,
    parameter int TIMEOUT = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic in_valid,
    output logic in_ready,
    output logic load_filter_en,
    output logic load_ifmap_en,
    output logic pe_clr,
    output logic pe_en,
    input  logic done_compute,
    output logic out_shift_en,
    output logic out_valid,
    input  logic out_ready,
    output logic busy,
    output logic done,
    output logic error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_F  = 3'd1;
    localparam logic [2:0] S_LOAD_I  = 3'd2;
    localparam logic [2:0] S_CLEAR   = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    // Terminal values of the shared counter in each counting state.
    localparam logic [9:0] F_LAST = 10'(FILTER * FILTER - 1);
    localparam logic [9:0] I_LAST = 10'(IFMAP * IFMAP - 1);
    localparam logic [9:0] O_LAST = 10'(OUT * OUT - 1);
    localparam logic [9:0] T_LAST = 10'(TIMEOUT - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [9:0] cnt;
    logic [9:0] cnt_nxt;
    logic       error_q;
    logic       error_nxt;

    // Output decode: purely from the current state and the live handshake
    // inputs, so loader and serializer strobes carry no extra cycle of latency.
    // The async reset forces IDLE immediately, which makes every output 0.
    always_comb begin
        in_ready       = (state == S_LOAD_F) || (state == S_LOAD_I);
        load_filter_en = (state == S_LOAD_F) && in_valid;
        load_ifmap_en  = (state == S_LOAD_I) && in_valid;
        pe_clr         = (state == S_CLEAR);
        pe_en          = (state == S_COMPUTE);
        out_valid      = (state == S_DRAIN);
        out_shift_en   = (state == S_DRAIN) && out_ready;
        busy           = (state != S_IDLE);
        done           = (state == S_FIN);
        error          = error_q;
    end

    // Next-state logic. Abort is checked before anything else so it beats a
    // coincident last transfer or done_compute. In COMPUTE, done_compute is
    // tested ahead of the timeout so a tie on the final cycle still drains.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        error_nxt = error_q;
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            error_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_LOAD_F;
                        cnt_nxt   = '0;
                    end
                end
                S_LOAD_F: begin
                    if (in_valid) begin
                        if (cnt == F_LAST) begin
                            state_nxt = S_LOAD_I;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 10'd1;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (in_valid) begin
                        if (cnt == I_LAST) begin
                            state_nxt = S_CLEAR;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 10'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    state_nxt = S_COMPUTE;
                    cnt_nxt   = '0;
                end
                S_COMPUTE: begin
                    if (done_compute) begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = '0;
                    end else if (cnt == T_LAST) begin
                        state_nxt = S_ERR;
                        error_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (cnt == O_LAST) begin
                            state_nxt = S_FIN;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 10'd1;
                        end
                    end
                end
                S_FIN: begin
                    state_nxt = S_IDLE;
                end
                S_ERR: begin
                    state_nxt = S_ERR;
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, shared counter and sticky error flag are the only registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            error_q <= error_nxt;
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_ctrl
//
// Drives conv_ctrl one cycle at a time and compares all ten outputs on every
// cycle against a job-progress model (bytes loaded, compute cycles spent,
// beats drained). Directed jobs pin the model with hand-computed counts, then
// a long randomized run exercises arbitrary interleavings.
// -----------------------------------------------------------------------------
module tb_conv_ctrl;

    localparam int IFMAP   = 5;
    localparam int FILTER  = 3;
    localparam int OUT     = IFMAP - FILTER + 1;
    localparam int TIMEOUT = 512;
    localparam int N_F     = FILTER * FILTER;
    localparam int N_I     = IFMAP * IFMAP;
    localparam int N_O     = OUT * OUT;

    localparam int PH_IDLE    = 0;
    localparam int PH_LOAD_F  = 1;
    localparam int PH_LOAD_I  = 2;
    localparam int PH_CLEAR   = 3;
    localparam int PH_COMPUTE = 4;
    localparam int PH_DRAIN   = 5;
    localparam int PH_FIN     = 6;
    localparam int PH_ERR     = 7;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic in_valid;
    logic in_ready;
    logic load_filter_en;
    logic load_ifmap_en;
    logic pe_clr;
    logic pe_en;
    logic done_compute;
    logic out_shift_en;
    logic out_valid;
    logic out_ready;
    logic busy;
    logic done;
    logic error;

    int compared;
    int mismatched;

    // job-progress model
    logic m_active;
    logic m_err;
    logic m_cleared;
    logic m_computed;
    int   m_loaded;
    int   m_cycles;
    int   m_beats;

    // observed-event counters
    int cyc;
    int n_lf;
    int n_li;
    int n_clr;
    int n_pe;
    int n_ov;
    int n_shift;
    int n_done;
    int n_drop;
    int last_shift_cyc;
    int done_cyc;
    logic prev_ov;
    logic prev_shift;

    conv_ctrl #(
        .IFMAP(IFMAP),
        .FILTER(FILTER),
        .OUT(OUT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .load_filter_en(load_filter_en),
        .load_ifmap_en(load_ifmap_en),
        .pe_clr(pe_clr),
        .pe_en(pe_en),
        .done_compute(done_compute),
        .out_shift_en(out_shift_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which part of the job we are in follows from how much work is done.
    function automatic int m_phase();
        if (!m_active)               return PH_IDLE;
        if (m_err)                   return PH_ERR;
        if (m_loaded < N_F)          return PH_LOAD_F;
        if (m_loaded < N_F + N_I)    return PH_LOAD_I;
        if (!m_cleared)              return PH_CLEAR;
        if (!m_computed)             return PH_COMPUTE;
        if (m_beats < N_O)           return PH_DRAIN;
        return PH_FIN;
    endfunction

    function automatic logic [9:0] m_expect();
        int   ph;
        logic lf;
        logic li;
        logic dr;
        ph = m_phase();
        lf = (ph == PH_LOAD_F);
        li = (ph == PH_LOAD_I);
        dr = (ph == PH_DRAIN);
        return {lf | li, lf & in_valid, li & in_valid, ph == PH_CLEAR,
                ph == PH_COMPUTE, dr & out_ready, dr, m_active,
                ph == PH_FIN, m_err};
    endfunction

    task automatic model_reset();
        m_active   = 1'b0;
        m_err      = 1'b0;
        m_cleared  = 1'b0;
        m_computed = 1'b0;
        m_loaded   = 0;
        m_cycles   = 0;
        m_beats    = 0;
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_step();
        if (!m_active) begin
            if (start) begin
                model_reset();
                m_active = 1'b1;
            end
        end else if (abort) begin
            model_reset();
        end else begin
            case (m_phase())
                PH_LOAD_F, PH_LOAD_I: if (in_valid) m_loaded++;
                PH_CLEAR:             m_cleared = 1'b1;
                PH_COMPUTE: begin
                    m_cycles++;
                    if (done_compute)            m_computed = 1'b1;
                    else if (m_cycles == TIMEOUT) m_err = 1'b1;
                end
                PH_DRAIN:             if (out_ready) m_beats++;
                PH_FIN:               m_active = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the whole output vector, plus event bookkeeping.
    task automatic check_output();
        logic [9:0] act;
        logic [9:0] exp;
        act = {in_ready, load_filter_en, load_ifmap_en, pe_clr, pe_en,
               out_shift_en, out_valid, busy, done, error};
        exp = m_expect();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL outputs cycle %0d: got %b, expected %b (ir lf li clr pe sh ov busy done err)",
                     cyc, act, exp);
        end
        cyc++;
        n_lf    += int'(load_filter_en);
        n_li    += int'(load_ifmap_en);
        n_clr   += int'(pe_clr);
        n_pe    += int'(pe_en);
        n_ov    += int'(out_valid);
        n_shift += int'(out_shift_en);
        if (out_shift_en) last_shift_cyc = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (prev_ov && !prev_shift && !out_valid) n_drop++;
        prev_ov    = out_valid;
        prev_shift = out_shift_en;
    endtask

    // One clock cycle: step the model at the edge, drive new inputs just
    // after it, compare outputs at the falling edge.
    task automatic apply_stimulus(input logic r, input logic st, input logic ab,
                                  input logic iv, input logic dc, input logic orr);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        rst          = r;
        start        = st;
        abort        = ab;
        in_valid     = iv;
        done_compute = dc;
        out_ready    = orr;
        if (r) model_reset();
        @(negedge clk);
        check_output();
    endtask

    task automatic go_idle();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_nominal();
        int lf0, li0, clr0, pe0, ov0, sh0, dn0;
        go_idle();
        lf0 = n_lf; li0 = n_li; clr0 = n_clr; pe0 = n_pe;
        ov0 = n_ov; sh0 = n_shift; dn0 = n_done;
        for (int i = 0; i < 75; i++)
            apply_stimulus(1'b0, i == 0, 1'b0, 1'b1, i == 56, 1'b1);
        check_val("nom_filter_loads", n_lf - lf0, 9);
        check_val("nom_ifmap_loads", n_li - li0, 25);
        check_val("nom_pe_clr", n_clr - clr0, 1);
        check_val("nom_pe_en_cycles", n_pe - pe0, 21);
        check_val("nom_out_valid_beats", n_ov - ov0, 9);
        check_val("nom_out_shifts", n_shift - sh0, 9);
        check_val("nom_done_pulses", n_done - dn0, 1);
        check_val("nom_done_lag", done_cyc - last_shift_cyc, 1);
    endtask

    task automatic run_backpressure();
        int ld0, sh0, ov0, dr0, dn0;
        go_idle();
        ld0 = n_lf + n_li; sh0 = n_shift; ov0 = n_ov; dr0 = n_drop; dn0 = n_done;
        for (int i = 0; i < 120; i++)
            apply_stimulus(1'b0, i == 0, 1'b0, (i % 2) == 1, 1'b1, (i % 2) == 0);
        check_val("bp_load_enables", n_lf + n_li - ld0, 34);
        check_val("bp_out_shifts", n_shift - sh0, 9);
        check_val("bp_out_valid_cycles", n_ov - ov0, 17);
        check_val("bp_out_valid_drops", n_drop - dr0, 0);
        check_val("bp_done_pulses", n_done - dn0, 1);
    endtask

    task automatic run_timeout(input logic tie);
        int dn0;
        go_idle();
        dn0 = n_done;
        for (int i = 0; i < 548; i++)
            apply_stimulus(1'b0, i == 0, 1'b0, 1'b1, tie && (i == 547), 1'b1);
        check_val("to_last_compute_pe_en", int'(pe_en), 1);
        check_val("to_last_compute_error", int'(error), 0);
        if (!tie) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val("to_error_set", int'(error), 1);
            check_val("to_error_busy", int'(busy), 1);
            check_val("to_error_pe_en", int'(pe_en), 0);
            for (int j = 0; j < 6; j++)
                apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            check_val("to_error_sticky", int'(error), 1);
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val("to_abort_busy", int'(busy), 0);
            check_val("to_abort_error", int'(error), 0);
        end else begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val("tie_drain_out_valid", int'(out_valid), 1);
            check_val("tie_drain_error", int'(error), 0);
            for (int j = 0; j < 12; j++)
                apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val("tie_done_pulses", n_done - dn0, 1);
            check_val("tie_error_after", int'(error), 0);
        end
    endtask

    task automatic run_abort_tie();
        int clr0;
        go_idle();
        clr0 = n_clr;
        for (int i = 0; i < 35; i++)
            apply_stimulus(1'b0, i == 0, i == 34, 1'b1, 1'b0, 1'b0);
        check_val("abt_last_xfer_en", int'(load_ifmap_en), 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("abt_busy_next", int'(busy), 0);
        check_val("abt_in_ready_next", int'(in_ready), 0);
        for (int j = 0; j < 3; j++)
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("abt_no_pe_clr", n_clr - clr0, 0);
    endtask

    task automatic run_async_reset();
        int lf0, li0;
        go_idle();
        for (int i = 0; i < 59; i++)
            apply_stimulus(1'b0, i == 0, 1'b0, 1'b1, i == 56, 1'b1);
        check_val("ar_in_drain", int'(out_valid), 1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("ar_outputs_zero",
                  int'({in_ready, load_filter_en, load_ifmap_en, pe_clr, pe_en,
                        out_shift_en, out_valid, busy, done, error}), 0);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++)
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("ar_stays_idle", int'(busy), 0);
        lf0 = n_lf; li0 = n_li;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("ar_fresh_filter_en", int'(load_filter_en), 1);
        for (int j = 0; j < 36; j++)
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("ar_fresh_filter_loads", n_lf - lf0, 9);
        check_val("ar_fresh_ifmap_loads", n_li - li0, 25);
    endtask

    task automatic run_random(input int cycles, input int dc_range);
        for (int i = 0; i < cycles; i++)
            apply_stimulus($urandom_range(0, 399) == 0,
                           $urandom_range(0, 3) == 0,
                           $urandom_range(0, 127) == 0,
                           $urandom_range(0, 3) != 0,
                           $urandom_range(0, dc_range) == 0,
                           $urandom_range(0, 1) == 1);
    endtask

    // Main sequence: reset, directed jobs, then randomized traffic.
    initial begin
        compared       = 0;
        mismatched     = 0;
        cyc            = 0;
        n_lf           = 0;
        n_li           = 0;
        n_clr          = 0;
        n_pe           = 0;
        n_ov           = 0;
        n_shift        = 0;
        n_done         = 0;
        n_drop         = 0;
        last_shift_cyc = 0;
        done_cyc       = 0;
        prev_ov        = 1'b0;
        prev_shift     = 1'b0;
        rst            = 1'b1;
        start          = 1'b1;
        abort          = 1'b0;
        in_valid       = 1'b1;
        done_compute   = 1'b0;
        out_ready      = 1'b1;
        model_reset();
        #2;
        check_val("reset_outputs",
                  int'({in_ready, load_filter_en, load_ifmap_en, pe_clr, pe_en,
                        out_shift_en, out_valid, busy, done, error}), 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("reset_busy_start_held", int'(busy), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] nominal job");
        run_nominal();
        $display("[TB] input gaps and output backpressure");
        run_backpressure();
        $display("[TB] compute timeout");
        run_timeout(1'b0);
        $display("[TB] timeout tie with done_compute");
        run_timeout(1'b1);
        $display("[TB] abort on last ifmap transfer");
        run_abort_tie();
        $display("[TB] asynchronous reset mid-drain");
        run_async_reset();
        $display("[TB] randomized traffic");
        run_random(3000, 7);
        run_random(1500, 700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 Parameter: IFMAP, default 5, ifmap side length in bytes.
REQ-002 Parameter: FILTER, default 3, filter side length in bytes.
REQ-003 Parameter: OUT, default IFMAP-FILTER+1, output side length.
REQ-004 Parameter: TIMEOUT, default 512, maximum COMPUTE cycles before error.
REQ-005 Port: clk  in  1  sole clock, all state on rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-high.
REQ-007 Port: start  in  1  begin one convolution job, sampled only in IDLE.
REQ-008 Port: abort  in  1  synchronous job cancel.
REQ-009 Port: in_valid  in  1  input byte stream valid.
REQ-010 Port: in_ready  out  1  controller accepts an input byte.
REQ-011 Port: load_filter_en  out  1  shift enable for the filter serial loader.
REQ-012 Port: load_ifmap_en  out  1  shift enable for the ifmap serial loader.
REQ-013 Port: pe_clr  out  1  PE array accumulator clear.
REQ-014 Port: pe_en  out  1  PE array compute enable.
REQ-015 Port: done_compute  in  1  PE array finished.
REQ-016 Port: out_shift_en  out  1  shift enable for the parallel-to-serial output stage.
REQ-017 Port: out_valid  out  1  output byte valid.
REQ-018 Port: out_ready  in  1  downstream accepts an output byte.
REQ-019 Port: busy  out  1  high in every state except IDLE.
REQ-020 Port: done  out  1  one-cycle job-complete pulse.
REQ-021 Port: error  out  1  sticky compute-timeout flag.

Function
REQ-022 FSM states: IDLE, LOAD_F, LOAD_I, CLEAR, COMPUTE, DRAIN, FIN, ERR; a single 10-bit counter cnt is shared by all states.
REQ-023 IDLE: start=1 -> LOAD_F, cnt<=0; start outside IDLE is ignored.
REQ-024 in_ready is 1 in LOAD_F and LOAD_I only; a transfer occurs when in_valid and in_ready are both 1.
REQ-025 load_filter_en = transfer in LOAD_F; load_ifmap_en = transfer in LOAD_I; both are combinational, with no extra latency.
REQ-026 LOAD_F: cnt increments per transfer; the transfer with cnt==FILTER*FILTER-1 -> LOAD_I, cnt<=0.
REQ-027 LOAD_I: cnt increments per transfer; the transfer with cnt==IFMAP*IFMAP-1 -> CLEAR.
REQ-028 in_valid gaps stall loading with no count change; no byte is lost or duplicated.
REQ-029 CLEAR: pe_clr=1 for exactly one cycle -> COMPUTE, cnt<=0; done_compute is ignored in CLEAR.
REQ-030 COMPUTE: pe_en=1 and cnt increments each cycle.
REQ-031 COMPUTE: done_compute=1 -> DRAIN, cnt<=0.
REQ-032 COMPUTE: cnt==TIMEOUT-1 without done_compute -> ERR.
REQ-033 COMPUTE: done_compute on the same cycle as the timeout wins, and the FSM goes to DRAIN.
REQ-034 DRAIN: out_valid=1; out_shift_en = out_valid and out_ready; cnt increments per accepted beat.
REQ-035 DRAIN: the beat with cnt==OUT*OUT-1 -> FIN; out_valid stays high while out_ready=0.
REQ-036 FIN: done=1 for one cycle -> IDLE; start is only honored on the following IDLE cycle.
REQ-037 ERR: error=1, busy=1, all enables 0; the FSM remains in ERR until abort.
REQ-038 abort=1 in any non-IDLE state -> IDLE next cycle, cnt<=0, error<=0.
REQ-039 abort has priority over every other transition, including a simultaneous last transfer or done_compute.
REQ-040 All outputs are decoded from the state register and the current inputs; only state, cnt and error are registered.

Reset
REQ-041 rst=1 immediately forces state=IDLE, cnt=0, error=0, without waiting for a clock edge.
REQ-042 While rst=1, all outputs read 0, including busy and done.
REQ-043 rst asserted mid-job discards the job; the first start after rst deasserts begins a fresh LOAD_F.

Verification
REQ-044 Nominal job: defaults, start, 9 then 25 back-to-back bytes, done_compute after 20 cycles, out_ready=1 -> 9 load_filter_en, 25 load_ifmap_en, 1 pe_clr, 9 out_valid beats, done pulse 1 cycle after the 9th beat.
REQ-045 Input gaps and output backpressure: in_valid toggling 1/0 and out_ready low every other cycle -> exactly 34 load enables and 9 out_shift_en, and out_valid never drops in DRAIN.
REQ-046 Timeout: done_compute is never asserted -> error=1 after 512 COMPUTE cycles and stays high; abort -> IDLE, error=0.
REQ-047 Timeout tie: done_compute on COMPUTE cycle 511 -> DRAIN, error stays 0.
REQ-048 Abort tie: abort together with the 25th ifmap transfer -> IDLE, no pe_clr, busy=0 next cycle.
REQ-049 Async reset: rst pulsed mid-DRAIN between clock edges -> outputs 0 before the next edge; the next start reloads from filter byte 0.
